mlp_layer_sequencer: RTL

- Runs MLP inference after the UART loader has filled model, weight and tensor memories and pulsed start_sig.
- Reads each layer descriptor from model memory: S1 = input size, S2 = output size, WN = weight line base.
- Drives port B of the tensor memory and of the 8 weight banks, and strobes the MAC/activation datapath with aligned control.
- Ping-pongs tensor halves between layers and handshakes each finished output neuron with the writeback stage.

---
 rtl/mlp_pkg.sv | 47 ++++
 rtl/mlp_layer_sequencer_if.sv | 44 ++++
 rtl/mlp_row_fetch.sv | 124 ++++++++++++
 rtl/mlp_layer_sequencer.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP layer sequencer.
// Descriptor layout, FSM encodings and the MAC control bundle.
package mlp_pkg;

  localparam int DESC_S1 = 0;
  localparam int DESC_S2 = 1;
  localparam int DESC_WN = 2;
  localparam int DESC_STRIDE = 4;
  localparam int WEIGHT_BANKS = 8;
  localparam int BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_M_REQ,
    S_M_S1,
    S_M_S2,
    S_M_WN,
    S_ROW,
    S_WB_WAIT,
    S_FIN
  } seq_state_t;

  typedef enum logic [2:0] {
    F_IDLE,
    F_ROW,
    F_LO,
    F_HI,
    F_DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic       clr;
    logic       en;
    logic       half;
    logic [3:0] mask;
    logic       last;
  } mac_ctl_t;

  function automatic logic [15:0] line_count(
    input logic [15:0] s1
  );
    logic [16:0] t;
    t = {1'b0, s1} + 17'd7;
    return {2'b00, t[16:3]};
  endfunction

endpackage

// File: rtl/mlp_layer_sequencer_if.sv
// Memory port B, MAC control and writeback handshake bundle.
// master = sequencer, slave = memories / datapath / writeback.
interface mlp_layer_sequencer_if #(
  parameter int MODEL_ADDR_WIDTH  = 10,
  parameter int WEIGHT_ADDR_WIDTH = 11,
  parameter int TENSOR_ADDR_WIDTH = 9
);
  logic                         mm_enb;
  logic [MODEL_ADDR_WIDTH-1:0]  mm_addrb;
  logic [17:0]                  mm_dob;
  logic                         wm_enb;
  logic [WEIGHT_ADDR_WIDTH-1:0] wm_addrb;
  logic                         tm_enb;
  logic [TENSOR_ADDR_WIDTH-1:0] tm_addrb;
  logic                         mac_clr;
  logic                         mac_en;
  logic                         mac_half;
  logic [3:0]                   mac_mask;
  logic                         mac_last;
  logic                         wb_req;
  logic [TENSOR_ADDR_WIDTH-1:0] wb_addr;
  logic                         wb_out_base;
  logic                         wb_ack;

  modport master (
    output mm_enb, mm_addrb,
    output wm_enb, wm_addrb,
    output tm_enb, tm_addrb,
    output mac_clr, mac_en, mac_half,
    output mac_mask, mac_last,
    output wb_req, wb_addr, wb_out_base,
    input  mm_dob, wb_ack
  );

  modport slave (
    input  mm_enb, mm_addrb,
    input  wm_enb, wm_addrb,
    input  tm_enb, tm_addrb,
    input  mac_clr, mac_en, mac_half,
    input  mac_mask, mac_last,
    input  wb_req, wb_addr, wb_out_base,
    output mm_dob, wb_ack
  );
endinterface

// File: rtl/mlp_row_fetch.sv
// Streams one output row: weight/tensor reads plus aligned MAC
// control, two cycles per weight line (low lanes, high lanes).
module mlp_row_fetch
  import mlp_pkg::*;
#(
  parameter int WEIGHT_ADDR_WIDTH = 11,
  parameter int TENSOR_ADDR_WIDTH = 9
) (
  input  logic                         clk_11MHz,
  input  logic                         resetn,
  input  logic                         row_start,
  input  logic                         in_half,
  input  logic [15:0]                  s1,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] wn,
  input  logic [WEIGHT_ADDR_WIDTH-1:0] r,
  output logic                         row_done,
  output logic                         wm_enb,
  output logic [WEIGHT_ADDR_WIDTH-1:0] wm_addrb,
  output logic                         tm_enb,
  output logic [TENSOR_ADDR_WIDTH-1:0] tm_addrb,
  output mac_ctl_t                     mac
);

  localparam int WAW = WEIGHT_ADDR_WIDTH;
  localparam int TAW = TENSOR_ADDR_WIDTH;

  fetch_state_t   state, state_nx;
  logic [15:0]    j, j_nx, lines;
  logic [WAW-1:0] row_base, row_base_nx;
  logic [3:0]     lo_mask, hi_mask;
  logic           last_line;
  mac_ctl_t       issue;

  function automatic logic [3:0] byte_mask(
    input logic [18:0] first,
    input logic [15:0] s1v
  );
    logic [3:0] m;
    for (int b = 0; b < 4; b++)
      m[b] = (first + 19'(b)) < {3'b000, s1v};
    return m;
  endfunction

  assign lines     = line_count(s1);
  assign last_line = (j == lines - 16'd1);
  assign lo_mask   = byte_mask({j, 3'b000}, s1);
  assign hi_mask   = byte_mask({j, 3'b100}, s1);

  // state, line index, row base and the MAC control delay stage
  always_ff @(posedge clk_11MHz) begin
    if (!resetn) begin
      state    <= F_IDLE;
      j        <= '0;
      row_base <= '0;
      mac      <= '0;
    end else begin
      state    <= state_nx;
      j        <= j_nx;
      row_base <= row_base_nx;
      mac      <= issue;
    end
  end

  // read issue, mask generation and line sequencing
  always_comb begin
    state_nx    = state;
    j_nx        = j;
    row_base_nx = row_base;
    issue       = '0;
    wm_enb      = 1'b0;
    wm_addrb    = '0;
    tm_enb      = 1'b0;
    tm_addrb    = '0;
    row_done    = 1'b0;
    unique case (state)
      F_IDLE: begin
        if (row_start) state_nx = F_ROW;
      end
      F_ROW: begin
        j_nx        = '0;
        row_base_nx = wn + r * lines[WAW-1:0];
        state_nx    = F_LO;
      end
      F_LO: begin
        wm_enb     = 1'b1;
        wm_addrb   = row_base + j[WAW-1:0];
        tm_enb     = 1'b1;
        tm_addrb   = {in_half, j[TAW-3:0], 1'b0};
        issue.en   = 1'b1;
        issue.clr  = (j == 16'd0);
        issue.mask = lo_mask;
        // an empty high half only happens on the last line
        if (hi_mask == 4'h0) begin
          issue.last = 1'b1;
          state_nx   = F_DRAIN;
        end else begin
          state_nx   = F_HI;
        end
      end
      F_HI: begin
        wm_enb     = 1'b1;
        wm_addrb   = row_base + j[WAW-1:0];
        tm_enb     = 1'b1;
        tm_addrb   = {in_half, j[TAW-3:0], 1'b1};
        issue.en   = 1'b1;
        issue.half = 1'b1;
        issue.mask = hi_mask;
        issue.last = last_line;
        if (last_line) begin
          state_nx = F_DRAIN;
        end else begin
          j_nx     = j + 16'd1;
          state_nx = F_LO;
        end
      end
      F_DRAIN: begin
        row_done = 1'b1;
        state_nx = F_IDLE;
      end
      default: state_nx = F_IDLE;
    endcase
  end

endmodule

// File: rtl/mlp_layer_sequencer.sv
// Layer descriptor walk and writeback handshake; row streaming
// is delegated to mlp_row_fetch. Tensor halves ping-pong per layer.
module mlp_layer_sequencer
  import mlp_pkg::*;
#(
  parameter int MODEL_ADDR_WIDTH  = 10,
  parameter int WEIGHT_ADDR_WIDTH = 11,
  parameter int TENSOR_ADDR_WIDTH = 9
) (
  input  logic                  clk_11MHz,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [7:0]            n_layers,
  mlp_layer_sequencer_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int MAW = MODEL_ADDR_WIDTH;
  localparam int WAW = WEIGHT_ADDR_WIDTH;
  localparam int TAW = TENSOR_ADDR_WIDTH;

  seq_state_t     state, state_nx;
  logic [7:0]     layer, layer_nx;
  logic [15:0]    r, r_nx;
  logic [15:0]    s1, s1_nx, s2, s2_nx;
  logic [15:0]    wn, wn_nx;
  logic           in_half, in_half_nx;
  logic           err_nx;
  logic           row_start, row_done;
  logic [MAW-1:0] desc_base;
  logic [8:0]     layer_inc;
  mac_ctl_t       mac;
  logic           unused_dob;

  assign unused_dob = ^bus.mm_dob[17:16];
  assign desc_base  = MAW'({layer, 2'b00});
  assign layer_inc  = {1'b0, layer} + 9'd1;

  mlp_row_fetch #(
    .WEIGHT_ADDR_WIDTH(WAW),
    .TENSOR_ADDR_WIDTH(TAW)
  ) u_fetch (
    .clk_11MHz(clk_11MHz),
    .resetn   (resetn),
    .row_start(row_start),
    .in_half  (in_half),
    .s1       (s1),
    .wn       (wn[WAW-1:0]),
    .r        (r[WAW-1:0]),
    .row_done (row_done),
    .wm_enb   (bus.wm_enb),
    .wm_addrb (bus.wm_addrb),
    .tm_enb   (bus.tm_enb),
    .tm_addrb (bus.tm_addrb),
    .mac      (mac)
  );

  assign bus.mac_clr  = mac.clr;
  assign bus.mac_en   = mac.en;
  assign bus.mac_half = mac.half;
  assign bus.mac_mask = mac.mask;
  assign bus.mac_last = mac.last;

  // descriptor, row/layer counters and sticky error
  always_ff @(posedge clk_11MHz) begin
    if (!resetn) begin
      state   <= S_IDLE;
      layer   <= '0;
      r       <= '0;
      s1      <= '0;
      s2      <= '0;
      wn      <= '0;
      in_half <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nx;
      layer   <= layer_nx;
      r       <= r_nx;
      s1      <= s1_nx;
      s2      <= s2_nx;
      wn      <= wn_nx;
      in_half <= in_half_nx;
      err     <= err_nx;
    end
  end

  // descriptor reads, row launch and writeback handshake
  always_comb begin
    state_nx        = state;
    layer_nx        = layer;
    r_nx            = r;
    s1_nx           = s1;
    s2_nx           = s2;
    wn_nx           = wn;
    in_half_nx      = in_half;
    err_nx          = err;
    row_start       = 1'b0;
    bus.mm_enb      = 1'b0;
    bus.mm_addrb    = '0;
    bus.wb_req      = 1'b0;
    bus.wb_addr     = '0;
    bus.wb_out_base = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          err_nx     = 1'b0;
          layer_nx   = '0;
          in_half_nx = 1'b0;
          r_nx       = '0;
          state_nx   = (n_layers == 8'd0) ? S_FIN : S_M_REQ;
        end
      end
      S_M_REQ: begin
        bus.mm_enb   = 1'b1;
        bus.mm_addrb = desc_base + MAW'(DESC_S1);
        state_nx     = S_M_S1;
      end
      S_M_S1: begin
        s1_nx        = bus.mm_dob[15:0];
        bus.mm_enb   = 1'b1;
        bus.mm_addrb = desc_base + MAW'(DESC_S2);
        state_nx     = S_M_S2;
      end
      S_M_S2: begin
        s2_nx        = bus.mm_dob[15:0];
        bus.mm_enb   = 1'b1;
        bus.mm_addrb = desc_base + MAW'(DESC_WN);
        state_nx     = S_M_WN;
      end
      S_M_WN: begin
        wn_nx = bus.mm_dob[15:0];
        if (s1 == 16'd0 || s2 == 16'd0) begin
          err_nx   = 1'b1;
          state_nx = S_FIN;
        end else begin
          r_nx      = '0;
          row_start = 1'b1;
          state_nx  = S_ROW;
        end
      end
      S_ROW: begin
        if (row_done) state_nx = S_WB_WAIT;
      end
      S_WB_WAIT: begin
        bus.wb_req      = 1'b1;
        bus.wb_addr     = r[TAW-1:0];
        bus.wb_out_base = ~in_half;
        if (bus.wb_ack) begin
          if (r < s2 - 16'd1) begin
            r_nx      = r + 16'd1;
            row_start = 1'b1;
            state_nx  = S_ROW;
          end else begin
            layer_nx   = layer_inc[7:0];
            in_half_nx = ~in_half;
            state_nx   = (layer_inc < {1'b0, n_layers})
                         ? S_M_REQ : S_FIN;
          end
        end
      end
      S_FIN: begin
        busy     = 1'b0;
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
